// File: rtl/sr_pulse_gen.sv
// sr_pulse_gen: per-channel debounced edge detector that drives SR flip-flop
// set/reset inputs. Each channel synchronizes its raw input with two flops,
// then a small FSM requires DEB consecutive stable cycles before it accepts
// a level change. A rise that is accepted emits a one-cycle s pulse, and a
// fall that is accepted emits a one-cycle r pulse. All outputs are registered.
module sr_pulse_gen #(
    parameter int W   = 1,
    parameter int DEB = 4
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] in,
    output logic [W-1:0] s,
    output logic [W-1:0] r,
    output logic [W-1:0] lvl,
    output logic [W-1:0] busy
);

    // Counter is sized to hold DEB so the width stays valid for DEB=1.
    localparam int CW = $clog2(DEB + 1);

    // Terminal count: a check that reaches this value with the input still
    // stable is accepted on the next edge.
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB - 1);

    typedef enum logic [1:0] {
        ST_LOW      = 2'd0,
        ST_RISE_CHK = 2'd1,
        ST_HIGH     = 2'd2,
        ST_FALL_CHK = 2'd3
    } state_t;

    logic [W-1:0] sy1;
    logic [W-1:0] sy2;

    // Two-flop synchronizer. It keeps sampling while en is low, so the FSM
    // sees a current value as soon as filtering is re-enabled.
    always_ff @(posedge clk) begin
        if (clr) begin
            sy1 <= '0;
            sy2 <= '0;
        end else begin
            sy1 <= in;
            sy2 <= sy1;
        end
    end

    for (genvar i = 0; i < W; i++) begin : g_ch

        state_t        state;
        state_t        state_nxt;
        logic [CW-1:0] cnt;
        logic [CW-1:0] cnt_nxt;
        logic          s_nxt;
        logic          r_nxt;
        logic          s_q;
        logic          r_q;
        logic          lvl_q;
        logic          busy_q;

        // Next-state logic. Disabling the filter aborts any check in
        // progress and suppresses pulses. The counter restarts from zero
        // whenever a check is entered or abandoned, and it is never
        // incremented past CNT_LAST.
        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            s_nxt     = 1'b0;
            r_nxt     = 1'b0;
            unique case (state)
                ST_LOW: begin
                    if (en && sy2[i]) begin
                        state_nxt = ST_RISE_CHK;
                        cnt_nxt   = '0;
                    end
                end
                ST_RISE_CHK: begin
                    if (!en || !sy2[i]) begin
                        state_nxt = ST_LOW;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt = ST_HIGH;
                        cnt_nxt   = '0;
                        s_nxt     = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (en && !sy2[i]) begin
                        state_nxt = ST_FALL_CHK;
                        cnt_nxt   = '0;
                    end
                end
                ST_FALL_CHK: begin
                    if (!en || sy2[i]) begin
                        state_nxt = ST_HIGH;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt = ST_LOW;
                        cnt_nxt   = '0;
                        r_nxt     = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            endcase
        end

        // State, counter and registered outputs. The outputs are computed
        // from the next state, so lvl and busy follow the state register
        // and the pulses last exactly one cycle.
        always_ff @(posedge clk) begin
            if (clr) begin
                state  <= ST_LOW;
                cnt    <= '0;
                s_q    <= 1'b0;
                r_q    <= 1'b0;
                lvl_q  <= 1'b0;
                busy_q <= 1'b0;
            end else begin
                state  <= state_nxt;
                cnt    <= cnt_nxt;
                s_q    <= s_nxt;
                r_q    <= r_nxt;
                lvl_q  <= (state_nxt == ST_HIGH) || (state_nxt == ST_FALL_CHK);
                busy_q <= (state_nxt == ST_RISE_CHK) || (state_nxt == ST_FALL_CHK);
            end
        end

        assign s[i]    = s_q;
        assign r[i]    = r_q;
        assign lvl[i]  = lvl_q;
        assign busy[i] = busy_q;

    end

endmodule

// File: tb/tb_sr_pulse_gen.sv
// Self-checking bench for sr_pulse_gen. Two instances share the clock, clr
// and en: one is a two-channel instance with DEB=4, the other a four-channel
// instance with DEB=1. A run-length reference model predicts s, r, lvl and
// busy on every cycle. The model tracks the accepted level and how many
// consecutive enabled cycles the synchronized input has disagreed with it.
module tb_sr_pulse_gen;

    localparam int WA = 2;
    localparam int DA = 4;
    localparam int WB = 4;
    localparam int DB = 1;

    logic          clk = 1'b0;
    logic          clr;
    logic          en;
    logic [WA-1:0] in_a;
    logic [WB-1:0] in_b;
    logic [WA-1:0] s_a, r_a, lvl_a, busy_a;
    logic [WB-1:0] s_b, r_b, lvl_b, busy_b;

    int checks = 0;
    int errors = 0;

    sr_pulse_gen #(.W(WA), .DEB(DA)) u_a (
        .clk(clk), .clr(clr), .en(en), .in(in_a),
        .s(s_a), .r(r_a), .lvl(lvl_a), .busy(busy_a)
    );

    sr_pulse_gen #(.W(WB), .DEB(DB)) u_b (
        .clk(clk), .clr(clr), .en(en), .in(in_b),
        .s(s_b), .r(r_b), .lvl(lvl_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    // Reference model state, indexed [instance][channel].
    bit m_h1  [2][4];
    bit m_h2  [2][4];
    bit m_lvl [2][4];
    bit m_s   [2][4];
    bit m_r   [2][4];
    int m_run [2][4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one rising edge, using the inputs currently
    // applied. A change is accepted after DEB+1 consecutive enabled cycles
    // in which the synchronized input disagrees with the accepted level.
    function automatic void model_edge();
        for (int d = 0; d < 2; d++) begin
            int  nch;
            int  deb;
            bit  v;
            bit  raw;
            nch = (d == 0) ? WA : WB;
            deb = (d == 0) ? DA : DB;
            for (int c = 0; c < nch; c++) begin
                raw = (d == 0) ? in_a[c] : in_b[c];
                m_s[d][c] = 1'b0;
                m_r[d][c] = 1'b0;
                if (clr) begin
                    m_h1[d][c]  = 1'b0;
                    m_h2[d][c]  = 1'b0;
                    m_lvl[d][c] = 1'b0;
                    m_run[d][c] = 0;
                end else begin
                    v = m_h2[d][c];
                    m_h2[d][c] = m_h1[d][c];
                    m_h1[d][c] = raw;
                    if (en && (v != m_lvl[d][c])) begin
                        m_run[d][c] = m_run[d][c] + 1;
                        if (m_run[d][c] == deb + 1) begin
                            m_lvl[d][c] = v;
                            m_run[d][c] = 0;
                            m_s[d][c]   = v;
                            m_r[d][c]   = !v;
                        end
                    end else begin
                        m_run[d][c] = 0;
                    end
                end
            end
        end
    endfunction

    // sel: 0=s 1=r 2=lvl 3=busy
    function automatic logic [3:0] exp_vec(input int d, input int sel);
        logic [3:0] v;
        v = '0;
        for (int c = 0; c < 4; c++) begin
            case (sel)
                0:       v[c] = m_s[d][c];
                1:       v[c] = m_r[d][c];
                2:       v[c] = m_lvl[d][c];
                default: v[c] = (m_run[d][c] != 0);
            endcase
        end
        if (d == 0) v[3:WA] = '0;
        return v;
    endfunction

    // Called at a falling edge with inputs already applied. Steps the model,
    // waits for the rising edge, checks everything, then returns at the
    // next falling edge.
    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        check("s_a",    {28'd0, 2'b00, s_a},    {28'd0, exp_vec(0, 0)});
        check("r_a",    {28'd0, 2'b00, r_a},    {28'd0, exp_vec(0, 1)});
        check("lvl_a",  {28'd0, 2'b00, lvl_a},  {28'd0, exp_vec(0, 2)});
        check("busy_a", {28'd0, 2'b00, busy_a}, {28'd0, exp_vec(0, 3)});
        check("s_b",    {28'd0, s_b},           {28'd0, exp_vec(1, 0)});
        check("r_b",    {28'd0, r_b},           {28'd0, exp_vec(1, 1)});
        check("lvl_b",  {28'd0, lvl_b},         {28'd0, exp_vec(1, 2)});
        check("busy_b", {28'd0, busy_b},        {28'd0, exp_vec(1, 3)});
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int  n;
        bit  seen;
        clr  = 1'b1;
        en   = 1'b1;
        in_a = '0;
        in_b = '0;
        @(negedge clk);

        // Reset state
        run(3);
        clr = 1'b0;
        run(3);

        // Accepted rise: count edges from the first sampling edge to s
        n = 0;
        in_a = 2'b01;
        do begin
            cycle();
            n++;
        end while (!s_a[0] && n < 20);
        check("lat_rise", n, DA + 3);
        run(4);

        // Accepted fall
        n = 0;
        in_a = 2'b00;
        do begin
            cycle();
            n++;
        end while (!r_a[0] && n < 20);
        check("lat_fall", n, DA + 3);
        run(4);

        // Short glitch: rejected, no pulse, lvl stays 0
        seen = 1'b0;
        in_a = 2'b01;
        for (int i = 0; i < 3; i++) begin cycle(); seen |= s_a[0] | r_a[0]; end
        in_a = 2'b00;
        for (int i = 0; i < 10; i++) begin cycle(); seen |= s_a[0] | r_a[0]; end
        check("glitch_pulse", {31'd0, seen}, 32'd0);

        // en dropped mid-check, then re-enabled with input still high
        in_a = 2'b01;
        run(4);
        en = 1'b0;
        run(2);
        en = 1'b1;
        run(10);
        in_a = 2'b00;
        run(10);

        // Simultaneous rises on several channels of the DEB=1 instance
        seen = 1'b0;
        in_b = 4'b1010;
        for (int i = 0; i < 6; i++) begin cycle(); if (s_b == 4'b1010) seen = 1'b1; end
        check("multi_rise", {31'd0, seen}, 32'd1);
        in_b = 4'b0000;
        run(6);

        // clr during a rise check, input held high through release
        in_a = 2'b01;
        run(5);
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        run(12);
        in_a = 2'b00;
        run(10);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < WA; c++)
                if ($urandom_range(0, 7) == 0) in_a[c] = ~in_a[c];
            for (int c = 0; c < WB; c++)
                if ($urandom_range(0, 3) == 0) in_b[c] = ~in_b[c];
            en  = ($urandom_range(0, 19) != 0);
            clr = ($urandom_range(0, 199) == 0);
            cycle();
        end
        clr = 1'b0;
        en  = 1'b1;
        run(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
